counter_bank_scheduler: RTL

- Shares one bank of NUM_CNT counters between NUM_REQ requesters.
- Each requester issues load (set to value) or increment operations against a counter index.
- A round-robin arbiter grants at most one operation per cycle. The bank is the single owner of counter state, so no two blocks hand-edit the same counter register.
- Sits between event-generating logic and status/readout logic.

---
 rtl/counter_bank_pkg.sv | 10 +
 rtl/counter_bank_scheduler_rr_arbiter.sv | 43 ++++
 rtl/counter_bank_scheduler.sv | 88 ++++++++
 3 files changed

// File: rtl/counter_bank_pkg.sv
// Shared opcode definitions for the counter bank scheduler and its requesters.
// Optional build macro used by the bank: COUNTER_BANK_SATURATE_EN.
package counter_bank_pkg;

    typedef enum logic {
        OP_INC  = 1'b0,
        OP_LOAD = 1'b1
    } op_t;

endpackage

// File: rtl/counter_bank_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req and pointer, zero latency.
// Pointer register moves past the winner only when advance is set; no backpressure of its own.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int PTR_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Scan upward from the pointer, wrapping modulo N; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/counter_bank_scheduler.sv
// Shared counter bank: one granted load/increment per cycle, applied at the accept edge; rd_data 1-cycle latency.
// Losers see req_ready low and hold their request; COUNTER_BANK_SATURATE_EN makes increments saturate.
module counter_bank_scheduler
    import counter_bank_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int NUM_CNT = 8,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = $clog2(NUM_CNT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    input  logic [NUM_REQ*CNT_W-1:0] req_value,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     wrap_pulse,
    output logic [IDX_W-1:0]         wrap_idx
);

    localparam int GW = $clog2(NUM_REQ);

    logic [CNT_W-1:0]   bank [NUM_CNT];
    logic [NUM_REQ-1:0] grant;
    logic [GW-1:0]      gidx;
    logic               fire;
    op_t                sel_op;
    logic [IDX_W-1:0]   sel_idx;
    logic [CNT_W-1:0]   sel_value;
    logic [CNT_W-1:0]   cur;
    logic [CNT_W-1:0]   nxt;
    logic               hit;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .advance   (fire),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req_ready = grant;
    assign fire      = |grant;

    // The current value is read from the bank at grant time, so back-to-back
    // operations on one index chain correctly through the register.
    always_comb begin
        sel_op    = op_t'(req_op[gidx]);
        sel_idx   = req_idx[int'(gidx)*IDX_W +: IDX_W];
        sel_value = req_value[int'(gidx)*CNT_W +: CNT_W];
        cur       = bank[sel_idx];
        hit       = fire && (sel_op == OP_INC) && (&cur);
        if (sel_op == OP_LOAD) begin
            nxt = sel_value;
`ifdef COUNTER_BANK_SATURATE_EN
        end else if (&cur) begin
            nxt = cur;
`endif
        end else begin
            nxt = cur + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                bank[i] <= '0;
            end
            rd_data    <= '0;
            wrap_pulse <= 1'b0;
            wrap_idx   <= '0;
        end else begin
            rd_data    <= bank[rd_idx];
            wrap_pulse <= hit;
            if (hit) begin
                wrap_idx <= sel_idx;
            end
            if (fire) begin
                bank[sel_idx] <= nxt;
            end
        end
    end

endmodule
